psum_accumulator_v2: RTL and testbench

- Parametrised successor to the channel accumulator in the convolution datapath.
- Receives signed partial sums from the PE array in channel-major order: all ofmap positions for channel 0, then for channel 1, and so on.
- Accumulates each position across input channels, then requantises the sum with a rounding arithmetic right shift and signed saturation.
- Streams results to the ofmap writer over a valid/ready handshake. Jobs are explicitly started and report completion.

---
 rtl/psum_accumulator_v2.sv | 201 ++++++++++++++++++++
 tb/tb_psum_accumulator_v2.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator_v2.sv
// ============================================================================
//  Module   : psum_accumulator_v2
//  Function : Channel-major partial-sum accumulator with rounding requantiser,
//             signed saturation and a valid/ready result stage.
//             Optional ReLU clamp on the result when ACC_RELU_EN is defined.
//  Revision : 2.0
// ============================================================================
`default_nettype none

module psum_accumulator_v2 #(
    parameter int PSUM_W    = 8,
    parameter int ACC_W     = 16,
    parameter int OUT_W     = 8,
    parameter int MAX_OFMAP = 1024,
    parameter int MAX_CH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [$clog2(MAX_OFMAP)-1:0]  ofmap_size,
    input  logic [$clog2(MAX_CH)-1:0]     ifmap_ch,
    input  logic [$clog2(ACC_W)-1:0]      out_shift,
    input  logic signed [PSUM_W-1:0]      psum_i,
    input  logic                          pvalid_i,
    output logic                          pready_o,
    output logic                          conv_valid_o,
    input  logic                          conv_ready_i,
    output logic signed [OUT_W-1:0]       conv_result_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int c_POS_W = $clog2(MAX_OFMAP);
    localparam int c_CH_W  = $clog2(MAX_CH);
    localparam int c_SH_W  = $clog2(ACC_W);

    localparam logic signed [ACC_W:0] c_SAT_MAX = (ACC_W+1)'((2 ** (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] c_SAT_MIN = (ACC_W+1)'(-(2 ** (OUT_W-1)));

`ifdef ACC_RELU_EN
    localparam bit c_RELU = 1'b1;
`else
    localparam bit c_RELU = 1'b0;
`endif

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic                    w_done_nxt;
    logic                    r_done;

    logic [c_POS_W-1:0]      r_pos;
    logic [c_CH_W-1:0]       r_ch;
    logic [c_POS_W-1:0]      r_cfg_size;
    logic [c_CH_W-1:0]       r_cfg_ch;
    logic [c_SH_W-1:0]       r_cfg_shift;

    logic signed [ACC_W-1:0] r_buf [MAX_OFMAP];
    logic                    r_fwd_en;
    logic [c_POS_W-1:0]      r_fwd_addr;
    logic signed [ACC_W-1:0] r_fwd_data;

    logic                    r_conv_valid;
    logic signed [OUT_W-1:0] r_conv_result;

    logic                    w_fire;
    logic                    w_last_ch;
    logic                    w_last_pos;
    logic signed [ACC_W-1:0] w_psum_ext;
    logic signed [ACC_W-1:0] w_rd;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W:0]   w_sum_x;
    logic [ACC_W:0]          w_round;
    logic signed [ACC_W:0]   w_rounded;
    logic signed [ACC_W:0]   w_shifted;
    logic signed [OUT_W-1:0] w_sat;

    assign w_last_ch  = (r_ch == r_cfg_ch);
    assign w_last_pos = (r_pos == r_cfg_size);
    assign pready_o   = (r_state == c_ST_RUN) && (!w_last_ch || !r_conv_valid || conv_ready_i);
    assign w_fire     = pvalid_i && pready_o;

    assign busy_o        = (r_state != c_ST_IDLE);
    assign done_o        = r_done;
    assign conv_valid_o  = r_conv_valid;
    assign conv_result_o = r_conv_result;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start_i) w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (w_fire && w_last_ch && w_last_pos) w_state_nxt = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if (!r_conv_valid || conv_ready_i) begin
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------- configuration and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos       <= '0;
            r_ch        <= '0;
            r_cfg_size  <= '0;
            r_cfg_ch    <= '0;
            r_cfg_shift <= '0;
        end else if (r_state == c_ST_IDLE && start_i) begin
            r_pos       <= '0;
            r_ch        <= '0;
            r_cfg_size  <= ofmap_size;
            r_cfg_ch    <= ifmap_ch;
            r_cfg_shift <= out_shift;
        end else if (w_fire) begin
            if (w_last_pos) begin
                r_pos <= '0;
                r_ch  <= r_ch + 1'b1;
            end else begin
                r_pos <= r_pos + 1'b1;
            end
        end
    end

    // ---------------------------------------------------- accumulation path
    // A single-position job reads the address written on the previous beat,
    // so the last write is kept aside and forwarded.
    assign w_psum_ext = {{(ACC_W-PSUM_W){psum_i[PSUM_W-1]}}, psum_i};
    assign w_rd       = (r_fwd_en && r_fwd_addr == r_pos) ? r_fwd_data : r_buf[r_pos];
    assign w_sum      = ((r_ch == '0) ? '0 : w_rd) + w_psum_ext;

    always_ff @(posedge clk) begin
        if (w_fire && !w_last_ch) r_buf[r_pos] <= w_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_en   <= 1'b0;
            r_fwd_addr <= '0;
            r_fwd_data <= '0;
        end else begin
            r_fwd_en   <= w_fire && !w_last_ch;
            r_fwd_addr <= r_pos;
            r_fwd_data <= w_sum;
        end
    end

    // ------------------------------------------------------- requantisation
    // Half-LSB rounding term is zero when the shift is zero.
    assign w_sum_x   = {w_sum[ACC_W-1], w_sum};
    assign w_round   = ((ACC_W+1)'(1) << r_cfg_shift) >> 1;
    assign w_rounded = w_sum_x + $signed(w_round);
    assign w_shifted = w_rounded >>> r_cfg_shift;

    always_comb begin
        w_sat = w_shifted[OUT_W-1:0];
        if (w_shifted > c_SAT_MAX) begin
            w_sat = c_SAT_MAX[OUT_W-1:0];
        end else if (w_shifted < c_SAT_MIN) begin
            w_sat = c_SAT_MIN[OUT_W-1:0];
        end
        if (c_RELU && w_sat[OUT_W-1]) w_sat = '0;
    end

    // --------------------------------------------------------- output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_conv_valid  <= 1'b0;
            r_conv_result <= '0;
        end else if (w_fire && w_last_ch) begin
            r_conv_valid  <= 1'b1;
            r_conv_result <= w_sat;
        end else if (r_conv_valid && conv_ready_i) begin
            r_conv_valid  <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_psum_accumulator_v2.sv
// ============================================================================
//  Module   : tb_psum_accumulator_v2
//  Function : Self-checking bench for psum_accumulator_v2 against an
//             arithmetic reference model (honours ACC_RELU_EN).
//  Revision : 2.0
// ============================================================================
`default_nettype none

module tb_psum_accumulator_v2;

    localparam int PSUM_W    = 8;
    localparam int ACC_W     = 16;
    localparam int OUT_W     = 8;
    localparam int MAX_OFMAP = 1024;
    localparam int MAX_CH    = 16;
    localparam int c_POS_W   = $clog2(MAX_OFMAP);
    localparam int c_CH_W    = $clog2(MAX_CH);
    localparam int c_SH_W    = $clog2(ACC_W);
    localparam int c_OMAX    = (2 ** (OUT_W-1)) - 1;
    localparam int c_OMIN    = -(2 ** (OUT_W-1));

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start_i;
    logic [c_POS_W-1:0]       ofmap_size;
    logic [c_CH_W-1:0]        ifmap_ch;
    logic [c_SH_W-1:0]        out_shift;
    logic signed [PSUM_W-1:0] psum_i;
    logic                     pvalid_i;
    logic                     pready_o;
    logic                     conv_valid_o;
    logic                     conv_ready_i;
    logic signed [OUT_W-1:0]  conv_result_o;
    logic                     busy_o;
    logic                     done_o;

    int checks = 0;
    int errors = 0;
    int psum_q[$];

    always #5 clk = ~clk;

    psum_accumulator_v2 #(
        .PSUM_W(PSUM_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
        .MAX_OFMAP(MAX_OFMAP), .MAX_CH(MAX_CH)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .ofmap_size(ofmap_size), .ifmap_ch(ifmap_ch), .out_shift(out_shift),
        .psum_i(psum_i), .pvalid_i(pvalid_i), .pready_o(pready_o),
        .conv_valid_o(conv_valid_o), .conv_ready_i(conv_ready_i),
        .conv_result_o(conv_result_o), .busy_o(busy_o), .done_o(done_o)
    );

    // Round-half-up arithmetic shift, clamp to the output range, optional ReLU.
    function automatic int model(input int sum, input int sh);
        int r;
        if (sh > 0) r = (sum + (1 << (sh - 1))) >>> sh;
        else        r = sum;
        if (r > c_OMAX) r = c_OMAX;
        if (r < c_OMIN) r = c_OMIN;
`ifdef ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    task automatic fill_random(input int cnt);
        psum_q.delete();
        for (int i = 0; i < cnt; i++) psum_q.push_back(int'($urandom_range(255)) - 128);
    endtask

    // Runs one job from psum_q (channel-major) and checks every handshake.
    task automatic run_job(input int size, input int nch, input int sh, input int ready_pct,
                           input int gap_pct, input bit lat_chk, input string name);
        int  n, total, idx, got, done_cnt, cyc, budget, beat_cycles, s;
        int  exp_q[$];
        bit  fire, in_last, prev_lf, exp_rdy;
        n = size + 1;
        total = n * (nch + 1);
        for (int p = 0; p < n; p++) begin
            s = 0;
            for (int c = 0; c <= nch; c++) s += psum_q[c*n + p];
            exp_q.push_back(model(s, sh));
        end
        idx = 0; got = 0; done_cnt = 0; cyc = 0; beat_cycles = 0; prev_lf = 1'b0;
        budget = total * 5 + 200;

        @(negedge clk);
        start_i = 1'b1; ofmap_size = c_POS_W'(size); ifmap_ch = c_CH_W'(nch);
        out_shift = c_SH_W'(sh); pvalid_i = 1'b0; conv_ready_i = 1'b1;
        @(negedge clk);

        while (!(got == n && done_cnt > 0) && cyc < budget) begin
            // stray starts with junk configuration must be ignored mid-job
            start_i      = (idx < total) && ($urandom_range(99) < 5);
            ofmap_size   = c_POS_W'($urandom);
            ifmap_ch     = c_CH_W'($urandom);
            out_shift    = c_SH_W'($urandom);
            pvalid_i     = (idx < total) && ($urandom_range(99) >= gap_pct);
            psum_i       = (idx < total) ? PSUM_W'(psum_q[idx]) : '0;
            conv_ready_i = ($urandom_range(99) < ready_pct);
            #1;
            fire    = pvalid_i && pready_o;
            in_last = (idx >= total - n);
            if (idx < total) begin
                beat_cycles++;
                exp_rdy = in_last ? (!conv_valid_o || conv_ready_i) : 1'b1;
                checks++;
                if (pready_o !== exp_rdy || busy_o !== 1'b1) begin
                    errors++;
                    $display("FAIL %s pready/busy beat %0d: pready=%b busy=%b want pready=%b busy=1",
                             name, idx, pready_o, busy_o, exp_rdy);
                end
            end
            if (lat_chk) begin
                checks++;
                if (conv_valid_o !== prev_lf) begin
                    errors++;
                    $display("FAIL %s latency cycle %0d: conv_valid=%b want %b", name, cyc, conv_valid_o, prev_lf);
                end
            end
            if (conv_valid_o === 1'b1 && conv_ready_i) begin
                checks++;
                if (got >= n) begin
                    errors++;
                    $display("FAIL %s extra result: got %0d results, want %0d", name, got + 1, n);
                end else if (conv_result_o !== OUT_W'(exp_q[got])) begin
                    errors++;
                    $display("FAIL %s result[%0d]: got %0d want %0d", name, got, conv_result_o, exp_q[got]);
                end
                got++;
            end
            if (done_o === 1'b1) begin
                done_cnt++;
                checks++;
                if (got != n || busy_o !== 1'b0 || idx != total) begin
                    errors++;
                    $display("FAIL %s done: results=%0d beats=%0d busy=%b want results=%0d beats=%0d busy=0",
                             name, got, idx, busy_o, n, total);
                end
            end
            prev_lf = fire && in_last;
            if (fire) idx++;
            cyc++;
            @(negedge clk);
        end
        start_i = 1'b0; pvalid_i = 1'b0;

        checks++;
        if (cyc >= budget) begin
            errors++;
            $display("FAIL %s timeout: results=%0d done=%0d want results=%0d done=1", name, got, done_cnt, n);
        end
        if (ready_pct == 100 && gap_pct == 0) begin
            checks++;
            if (beat_cycles != total) begin
                errors++;
                $display("FAIL %s bubbles: input cycles %0d want %0d", name, beat_cycles, total);
            end
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (done_o !== 1'b0 || conv_valid_o !== 1'b0 || busy_o !== 1'b0 || pready_o !== 1'b0) begin
                errors++;
                $display("FAIL %s idle after job: done=%b valid=%b busy=%b pready=%b want 0000",
                         name, done_o, conv_valid_o, busy_o, pready_o);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; pvalid_i = 1'b0; conv_ready_i = 1'b1; psum_i = '0;
        ofmap_size = '0; ifmap_ch = '0; out_shift = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (pready_o !== 1'b0 || conv_valid_o !== 1'b0 || busy_o !== 1'b0 ||
            done_o !== 1'b0 || conv_result_o !== '0) begin
            errors++;
            $display("FAIL reset: pready=%b valid=%b busy=%b done=%b result=%0d want all 0",
                     pready_o, conv_valid_o, busy_o, done_o, conv_result_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_defaults();
        fill_random(1024 * 16);
        run_job(1023, 15, 0, 100, 0, 1'b0, "defaults");
    endtask

    task automatic test_single_channel();
        psum_q = '{5, -7, 127, -128};
        run_job(3, 0, 0, 100, 0, 1'b1, "single_ch");
    endtask

    task automatic test_sat_round();
        psum_q = '{100, 100};
        run_job(0, 1, 0, 100, 0, 1'b0, "sat_sh0");
        run_job(0, 1, 1, 100, 0, 1'b0, "sat_sh1");
        psum_q = '{-3, 0};
        run_job(0, 1, 1, 100, 0, 1'b0, "round_neg");
    endtask

    task automatic test_backpressure();
        fill_random(64 * 4);
        run_job(63, 3, int'($urandom_range(6)), 30, 20, 1'b0, "backpressure");
        for (int j = 0; j < 4; j++) begin
            fill_random(16 * 6);
            run_job(15, 5, int'($urandom_range(15)), 60, 10, 1'b0, "rand_shift");
        end
    endtask

    task automatic test_forwarding();
        psum_q = '{10, 20, 30, 40};
        run_job(0, 3, 0, 100, 0, 1'b0, "forwarding");
    endtask

    task automatic test_abort_reset();
        @(negedge clk);
        start_i = 1'b1; ofmap_size = c_POS_W'(3); ifmap_ch = c_CH_W'(3); out_shift = '0;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pvalid_i = 1'b1; psum_i = PSUM_W'($urandom_range(255));
            @(negedge clk);
        end
        pvalid_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || pready_o !== 1'b0 || conv_valid_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b pready=%b valid=%b done=%b want 0000",
                     busy_o, pready_o, conv_valid_o, done_o);
        end
        rst = 1'b0;
        @(negedge clk);
        fill_random(4 * 2);
        run_job(3, 1, 0, 100, 0, 1'b0, "after_abort");
    endtask

    task automatic test_relu();
        psum_q = '{-50, 60};
        run_job(1, 0, 0, 100, 0, 1'b1, "relu");
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_sat_round();
        test_forwarding();
        test_backpressure();
        test_abort_reset();
        test_relu();
        test_defaults();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
